// File: rtl/xt_bus_pkg.sv
// Shared definitions for the XT peripheral-side bus blocks.
//
// Contents:
//   xt_target_state_t : I/O responder transaction state (IDLE, ACCESS, DONE)
//   XT_IO_ADDR_BITS   : number of address bits decoded for I/O ports
//   XT_FLOAT_DATA     : value returned when the backend never answers (floating bus)
package xt_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } xt_target_state_t;

   localparam int unsigned XT_IO_ADDR_BITS = 10;
   localparam logic [7:0]  XT_FLOAT_DATA   = 8'hFF;

endpackage

// File: rtl/xt_io_target.sv
// XT I/O-channel responder.
//
// Decodes CPU I/O read/write strobes that hit a 2**IO_SIZE_LOG2 port window at IO_BASE and
// turns each strobe assertion into exactly one request/acknowledge transaction toward a
// simple register backend. While the backend works, io_channel_ready is held low to stretch
// the bus cycle; a missing acknowledge is cut off after TIMEOUT cycles.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   address               : bus address, bits [9:0] decoded
//   internal_data_bus     : write data from the bus
//   io_read_n, io_write_n : I/O strobes, active low
//   address_enable_n      : low for CPU cycles, high for DMA (ignored)
//   io_channel_ready      : low inserts wait states (combinational)
//   data_bus_out          : read data toward the chipset data mux
//   data_bus_out_enable   : data_bus_out must drive the bus
//   req_valid/req_write/req_offset/req_wdata : backend request
//   req_ack, req_rdata    : backend completion and read data
//   timeout_pulse         : one-cycle flag for a forced completion
module xt_io_target
   import xt_bus_pkg::*;
#(
   parameter logic [XT_IO_ADDR_BITS-1:0] IO_BASE      = 10'h300,
   parameter int unsigned                IO_SIZE_LOG2 = 3,
   parameter int unsigned                TIMEOUT      = 15
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [19:0]             address,
   input  logic [7:0]              internal_data_bus,
   input  logic                    io_read_n,
   input  logic                    io_write_n,
   input  logic                    address_enable_n,
   output logic                    io_channel_ready,
   output logic [7:0]              data_bus_out,
   output logic                    data_bus_out_enable,
   output logic                    req_valid,
   output logic                    req_write,
   output logic [IO_SIZE_LOG2-1:0] req_offset,
   output logic [7:0]              req_wdata,
   input  logic                    req_ack,
   input  logic [7:0]              req_rdata,
   output logic                    timeout_pulse
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   xt_target_state_t state_q, state_d;

   logic                    rd_q, wr_q;
   logic                    armed_q, armed_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    req_valid_q, req_valid_d;
   logic                    req_write_q, req_write_d;
   logic [IO_SIZE_LOG2-1:0] req_offset_q, req_offset_d;
   logic [7:0]              req_wdata_q, req_wdata_d;
   logic [7:0]              dbo_q, dbo_d;
   logic                    tpulse_q, tpulse_d;

   logic       hit;
   logic       rd_fall, wr_fall;
   logic       start;
   logic [7:0] cnt_inc;
   logic       tmo_hit;

   // Upper address bits are not part of I/O decoding.
   logic unused_addr;
   assign unused_addr = ^address[19:XT_IO_ADDR_BITS];

   // ---------------------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------------------
   assign hit = ~address_enable_n &&
                (address[XT_IO_ADDR_BITS-1:IO_SIZE_LOG2] ==
                 IO_BASE[XT_IO_ADDR_BITS-1:IO_SIZE_LOG2]);

   assign rd_fall = ~io_read_n & rd_q;
   assign wr_fall = ~io_write_n & wr_q;

   // A strobe that was already low when reset was applied must be released before it can
   // start a cycle; armed_q tracks that both strobes have been seen high since reset.
   assign start = hit && armed_q &&
                  ((rd_fall && io_write_n) || (wr_fall && io_read_n));

   assign cnt_inc = cnt_q + 8'd1;
   assign tmo_hit = (cnt_inc == TimeoutCnt);

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = ACCESS;
         end
         ACCESS: begin
            if (req_ack || tmo_hit) state_d = DONE;
         end
         DONE: begin
            // Wait for both strobes high so a held strobe cannot retrigger.
            if (io_read_n && io_write_n) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------------
   always_comb begin
      io_channel_ready    = 1'b1;
      data_bus_out_enable = 1'b0;
      unique case (state_q)
         IDLE:    io_channel_ready = ~start;
         ACCESS:  io_channel_ready = 1'b0;
         DONE:    data_bus_out_enable = ~req_write_q & ~io_read_n;
         default: io_channel_ready = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // Request / response datapath
   // ---------------------------------------------------------------------------------------
   always_comb begin
      armed_d      = armed_q | (io_read_n & io_write_n);
      cnt_d        = cnt_q;
      req_valid_d  = req_valid_q;
      req_write_d  = req_write_q;
      req_offset_d = req_offset_q;
      req_wdata_d  = req_wdata_q;
      dbo_d        = dbo_q;
      tpulse_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               req_valid_d  = 1'b1;
               req_write_d  = ~io_write_n;
               req_offset_d = address[IO_SIZE_LOG2-1:0];
               req_wdata_d  = internal_data_bus;
               cnt_d        = 8'd0;
            end
         end
         ACCESS: begin
            cnt_d = cnt_inc;
            // Ack takes priority over a timeout landing in the same cycle.
            if (req_ack) begin
               req_valid_d = 1'b0;
               if (!req_write_q) dbo_d = req_rdata;
            end else if (tmo_hit) begin
               req_valid_d = 1'b0;
               dbo_d       = XT_FLOAT_DATA;
               tpulse_d    = 1'b1;
            end
         end
         DONE: begin
            cnt_d = cnt_q;
         end
         default: begin
            req_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_q         <= 1'b1;
         wr_q         <= 1'b1;
         armed_q      <= 1'b0;
         cnt_q        <= 8'd0;
         req_valid_q  <= 1'b0;
         req_write_q  <= 1'b0;
         req_offset_q <= '0;
         req_wdata_q  <= 8'd0;
         dbo_q        <= 8'd0;
         tpulse_q     <= 1'b0;
      end else begin
         rd_q         <= io_read_n;
         wr_q         <= io_write_n;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         req_valid_q  <= req_valid_d;
         req_write_q  <= req_write_d;
         req_offset_q <= req_offset_d;
         req_wdata_q  <= req_wdata_d;
         dbo_q        <= dbo_d;
         tpulse_q     <= tpulse_d;
      end
   end

   assign req_valid     = req_valid_q;
   assign req_write     = req_write_q;
   assign req_offset    = req_offset_q;
   assign req_wdata     = req_wdata_q;
   assign data_bus_out  = dbo_q;
   assign timeout_pulse = tpulse_q;

endmodule
